// File: rtl/uart_rx_core_if.sv
`default_nettype none
// ============================================================================
// uart_rx_core_if : serial line, control fields and status path of the UART RX
// Revision: 1.0
// ============================================================================
interface uart_rx_core_if;
  logic        rx;
  logic        cfg_active;
  logic [1:0]  cfg_frame;
  logic [1:0]  cfg_parity;
  logic        cfg_stop;
  logic [3:0]  cfg_baud;
  logic        st_reg_re;
  logic [11:0] st_reg_rdata;
  logic        rx_busy;

  modport master (
    output rx, cfg_active, cfg_frame, cfg_parity, cfg_stop, cfg_baud, st_reg_re,
    input  st_reg_rdata, rx_busy
  );

  modport slave (
    input  rx, cfg_active, cfg_frame, cfg_parity, cfg_stop, cfg_baud, st_reg_re,
    output st_reg_rdata, rx_busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// uart_rx_core : 16x-oversampled UART receiver with sticky 12-bit status word.
// Option UART_RX_MAJORITY_EN: 2-of-3 vote of ticks 7/8/9 instead of tick 8.
// Revision: 1.0
// ============================================================================
module uart_rx_core #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  wire logic     clk,
  input  wire logic     arst_n,
  uart_rx_core_if.slave bus
);

  localparam int unsigned C_DIV_W = $clog2(CLK_FREQ_HZ / (16 * 110) + 1);
  localparam int unsigned C_MID   = OVERSAMPLE / 2 - 1;

  localparam logic [2:0] C_IDLE   = 3'd0;
  localparam logic [2:0] C_START  = 3'd1;
  localparam logic [2:0] C_DATA   = 3'd2;
  localparam logic [2:0] C_PARITY = 3'd3;
  localparam logic [2:0] C_STOP1  = 3'd4;
  localparam logic [2:0] C_STOP2  = 3'd5;

  function automatic logic [C_DIV_W-1:0] div_m1(input logic [3:0] sel);
    int unsigned baud;
    case (sel)
      4'd0:    baud = 110;
      4'd1:    baud = 150;
      4'd2:    baud = 300;
      4'd3:    baud = 600;
      4'd4:    baud = 1200;
      4'd5:    baud = 2400;
      4'd6:    baud = 4800;
      4'd8:    baud = 19200;
      4'd9:    baud = 38400;
      4'd10:   baud = 57600;
      4'd11:   baud = 115200;
      default: baud = 9600;
    endcase
    return C_DIV_W'(CLK_FREQ_HZ / (16 * baud) - 1);
  endfunction

  logic               r_rx_meta, r_rx_sync, r_rx_prev;
  logic [2:0]         r_state, w_state_nxt;
  logic [1:0]         r_frame, r_parity;
  logic               r_stop;
  logic [C_DIV_W-1:0] r_div_m1, r_tick_cnt;
  logic [3:0]         r_os_cnt;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic               r_par_pend, r_frm_pend;
  logic [7:0]         r_data;
  logic               r_valid, r_perr, r_ferr, r_ovr;

  logic               w_start, w_tick, w_samp, w_bit;
  logic               w_busy, w_commit;
  logic [2:0]         w_nbits_m1;
  logic               w_par_en;
  logic [7:0]         w_data;
  logic               w_frm_now;
  logic [7:0]         w_data_n;
  logic               w_valid_n, w_perr_n, w_ferr_n, w_ovr_n;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_start    = (r_state == C_IDLE) && bus.cfg_active && r_rx_prev && !r_rx_sync;
  assign w_tick     = (r_state != C_IDLE) && (r_tick_cnt == '0);
  assign w_nbits_m1 = 3'd4 + {1'b0, r_frame};
  assign w_par_en   = ^r_parity;
  assign w_data     = r_shift >> (3'd7 - w_nbits_m1);
  assign w_frm_now  = r_frm_pend | ~w_bit;

`ifdef UART_RX_MAJORITY_EN
  logic r_s_a, r_s_b;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_s_a <= 1'b1;
      r_s_b <= 1'b1;
    end else begin
      if (w_tick && r_os_cnt == 4'(C_MID - 1)) r_s_a <= r_rx_sync;
      if (w_tick && r_os_cnt == 4'(C_MID))     r_s_b <= r_rx_sync;
    end
  end
  assign w_samp = w_tick && (r_os_cnt == 4'(C_MID + 1));
  assign w_bit  = (r_s_a & r_s_b) | (r_s_a & r_rx_sync) | (r_s_b & r_rx_sync);
`else
  assign w_samp = w_tick && (r_os_cnt == 4'(C_MID));
  assign w_bit  = r_rx_sync;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= C_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state != C_IDLE && !bus.cfg_active) begin
      w_state_nxt = C_IDLE;
    end else begin
      case (r_state)
        C_IDLE:   if (w_start) w_state_nxt = C_START;
        C_START:  if (w_samp) w_state_nxt = w_bit ? C_IDLE : C_DATA;
        C_DATA:   if (w_samp && r_bit_cnt == w_nbits_m1)
                    w_state_nxt = w_par_en ? C_PARITY : C_STOP1;
        C_PARITY: if (w_samp) w_state_nxt = C_STOP1;
        C_STOP1:  if (w_samp) w_state_nxt = r_stop ? C_STOP2 : C_IDLE;
        C_STOP2:  if (w_samp) w_state_nxt = C_IDLE;
        default:  w_state_nxt = C_IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy   = (r_state != C_IDLE);
    w_commit = w_samp && bus.cfg_active &&
               ((r_state == C_STOP1 && !r_stop) || r_state == C_STOP2);
  end

  // Shadow config is captured on the start edge so the frame in flight is stable.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_frame    <= '0;
      r_parity   <= '0;
      r_stop     <= 1'b0;
      r_div_m1   <= '0;
      r_tick_cnt <= '0;
      r_os_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_pend <= 1'b0;
      r_frm_pend <= 1'b0;
    end else if (w_start) begin
      r_frame    <= bus.cfg_frame;
      r_parity   <= bus.cfg_parity;
      r_stop     <= bus.cfg_stop;
      r_div_m1   <= div_m1(bus.cfg_baud);
      r_tick_cnt <= div_m1(bus.cfg_baud);
      r_os_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_par_pend <= 1'b0;
      r_frm_pend <= 1'b0;
    end else if (r_state != C_IDLE) begin
      if (w_tick) begin
        r_tick_cnt <= r_div_m1;
        r_os_cnt   <= r_os_cnt + 4'd1;
      end else begin
        r_tick_cnt <= r_tick_cnt - 1'b1;
      end
      if (w_samp) begin
        case (r_state)
          C_DATA: begin
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          C_PARITY:         r_par_pend <= (w_bit != ((^w_data) ^ r_parity[1]));
          C_STOP1, C_STOP2: if (!w_bit) r_frm_pend <= 1'b1;
          default:          ;
        endcase
      end
    end
  end

  // A read in the commit cycle is applied first, so it frees the slot for the new frame.
  always_comb begin
    w_data_n  = r_data;
    w_valid_n = r_valid & ~bus.st_reg_re;
    w_perr_n  = r_perr  & ~bus.st_reg_re;
    w_ferr_n  = r_ferr  & ~bus.st_reg_re;
    w_ovr_n   = r_ovr   & ~bus.st_reg_re;
    if (w_commit) begin
      if (w_valid_n) begin
        w_ovr_n = 1'b1;
      end else begin
        w_data_n  = w_data;
        w_valid_n = 1'b1;
        w_perr_n  = w_perr_n | r_par_pend;
        w_ferr_n  = w_ferr_n | w_frm_now;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_data  <= w_data_n;
      r_valid <= w_valid_n;
      r_perr  <= w_perr_n;
      r_ferr  <= w_ferr_n;
      r_ovr   <= w_ovr_n;
    end
  end

  assign bus.st_reg_rdata = {r_ovr, r_ferr, r_perr, r_valid, r_data};
  assign bus.rx_busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_core : directed UART frames with a queue scoreboard checked at
// every end of a receive (rx_busy falling). Revision: 1.0
// ============================================================================
module tb_uart_rx_core;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_core_if bus();
  uart_rx_core #(.CLK_FREQ_HZ(50_000_000), .OVERSAMPLE(16)) dut (
    .clk(clk), .arst_n(arst_n), .bus(bus)
  );

  localparam int BP_FAST = 16 * 27;

  int          checks = 0;
  int          failures = 0;
  logic [11:0] sb[$];
  logic [11:0] mon_exp;
  bit          mon_en = 1'b1;
  logic        prev_busy = 1'b0;
  int          cyc_cnt = 0;
  int          commit_cyc = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && prev_busy === 1'b1 && bus.rx_busy === 1'b0) begin
      commit_cyc = cyc_cnt;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL frame_unexpected: got %h expected no frame end", bus.st_reg_rdata);
      end else begin
        mon_exp = sb.pop_front();
        check("frame_status", bus.st_reg_rdata, mon_exp);
      end
    end
    prev_busy = bus.rx_busy;
  end

  task automatic drive(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input int par, input bit flip,
                            input logic s1, input logic s2, input int ns, input int div);
    int         bp;
    logic [7:0] m;
    logic       p;
    bp = 16 * div;
    m  = 8'((1 << n) - 1);
    p  = ^(d & m);
    drive(1'b0, bp);
    for (int i = 0; i < n; i++) drive(d[i], bp);
    if (par == 1)      drive(p ^ flip, bp);
    else if (par == 2) drive(~p ^ flip, bp);
    drive(s1, bp);
    if (ns == 2) drive(s2, bp);
  endtask

  task automatic set_cfg(input logic [1:0] fr, input logic [1:0] pa, input logic st, input logic [3:0] bd);
    bus.cfg_frame  = fr;
    bus.cfg_parity = pa;
    bus.cfg_stop   = st;
    bus.cfg_baud   = bd;
  endtask

  task automatic read_check(input string name, input logic [11:0] exp);
    bus.st_reg_re = 1'b1;
    @(posedge clk);
    #1;
    bus.st_reg_re = 1'b0;
    check(name, bus.st_reg_rdata, exp);
  endtask

  task automatic wait_sb(input string name);
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s: got %0d pending frames expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, k, tgt;
    bus.rx = 1'b1;
    bus.cfg_active = 1'b1;
    bus.st_reg_re = 1'b0;
    set_cfg(2'b11, 2'b00, 1'b0, 4'd7);
    repeat (4) @(posedge clk);
    #1;
    check("reset_rdata", bus.st_reg_rdata, 12'h000);
    check("reset_busy", {11'b0, bus.rx_busy}, 12'h000);
    arst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 8N1 at 9600
    sb.push_back(12'h1A5);
    send_frame(8'hA5, 8, 0, 1'b0, 1'b1, 1'b1, 1, 325);
    wait_sb("drain_9600");
    read_check("read_9600", 12'h0A5);

    // 7E1 at 115200, good then flipped parity
    set_cfg(2'b10, 2'b01, 1'b0, 4'd11);
    sb.push_back(12'h153);
    send_frame(8'h53, 7, 1, 1'b0, 1'b1, 1'b1, 1, 27);
    wait_sb("drain_7e1");
    read_check("read_7e1", 12'h053);
    sb.push_back(12'h353);
    send_frame(8'h53, 7, 1, 1'b1, 1'b1, 1'b1, 1, 27);
    wait_sb("drain_7e1_bad");
    read_check("read_7e1_bad", 12'h053);

    // 8N2: bad second stop, then overrun without a read
    set_cfg(2'b11, 2'b00, 1'b1, 4'd11);
    sb.push_back(12'h53C);
    send_frame(8'h3C, 8, 0, 1'b0, 1'b1, 1'b0, 2, 27);
    drive(1'b1, 4);
    wait_sb("drain_8n2");
    sb.push_back(12'hD3C);
    send_frame(8'hC3, 8, 0, 1'b0, 1'b1, 1'b1, 2, 27);
    wait_sb("drain_ovr");
    read_check("read_ovr", 12'h03C);

    // false start: 3-tick glitch
    sb.push_back(12'h03C);
    drive(1'b0, 3 * 27);
    drive(1'b1, BP_FAST);
    wait_sb("drain_false");

    // break on a 5N1 frame, line then held low for another bit
    set_cfg(2'b00, 2'b00, 1'b0, 4'd11);
    sb.push_back(12'h500);
    send_frame(8'h00, 5, 0, 1'b0, 1'b0, 1'b0, 1, 27);
    drive(1'b0, BP_FAST);
    drive(1'b1, BP_FAST);
    wait_sb("drain_break");
    read_check("read_break", 12'h000);

    // same-cycle read and commit: measure commit offset, then hit it
    sb.push_back(12'h111);
    start = cyc_cnt;
    send_frame(8'hF1, 5, 0, 1'b0, 1'b1, 1'b1, 1, 27);
    wait_sb("drain_cal");
    k = commit_cyc - start;
    sb.push_back(12'h116);
    start = cyc_cnt;
    tgt = start + k - 1;
    fork
      send_frame(8'h16, 5, 0, 1'b0, 1'b1, 1'b1, 1, 27);
      begin
        while (cyc_cnt < tgt) begin
          @(posedge clk);
          #1;
        end
        bus.st_reg_re = 1'b1;
        @(posedge clk);
        #1;
        bus.st_reg_re = 1'b0;
      end
    join
    wait_sb("drain_same");
    read_check("read_same", 12'h016);

    // receiver disabled mid-frame
    sb.push_back(12'h016);
    drive(1'b0, BP_FAST);
    drive(1'b1, BP_FAST);
    drive(1'b0, BP_FAST / 2);
    bus.cfg_active = 1'b0;
    drive(1'b1, BP_FAST);
    bus.cfg_active = 1'b1;
    wait_sb("drain_abort");

    // asynchronous reset during DATA
    drive(1'b0, BP_FAST);
    drive(1'b1, BP_FAST);
    drive(1'b0, BP_FAST / 2);
    mon_en = 1'b0;
    arst_n = 1'b0;
    #1;
    check("rst_mid_rdata", bus.st_reg_rdata, 12'h000);
    check("rst_mid_busy", {11'b0, bus.rx_busy}, 12'h000);
    bus.rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    arst_n = 1'b1;
    repeat (2 * BP_FAST) @(posedge clk);
    #1;
    check("rst_after_rdata", bus.st_reg_rdata, 12'h000);
    check("rst_after_busy", {11'b0, bus.rx_busy}, 12'h000);
    mon_en = 1'b1;

`ifdef UART_RX_MAJORITY_EN
    // 1-clk glitch inside a data bit is outvoted
    set_cfg(2'b11, 2'b00, 1'b0, 4'd11);
    sb.push_back(12'h1FF);
    fork
      send_frame(8'hFF, 8, 0, 1'b0, 1'b1, 1'b1, 1, 27);
      begin
        repeat (2 * BP_FAST + BP_FAST / 2) @(posedge clk);
        #1;
        bus.rx = 1'b0;
        @(posedge clk);
        #1;
        bus.rx = 1'b1;
      end
    join
    wait_sb("drain_glitch");
`endif

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_empty: got %0d entries expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
